// File: rtl/the_ex_stage.sv
// EX/MEM pipeline register: captures EX results for the memory stage.
// Latency: one clk cycle from input to output; no combinational path.
// Backpressure: stall holds every output; flush loads a zero bubble and overrides stall.
module the_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        ctlwb_out,
  input  logic [2:0]        ctlm_out,
  input  logic [DATA_W-1:0] adder_out,
  input  logic              aluzero,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] readdat2,
  input  logic [REG_W-1:0]  mux_out,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic [DATA_W-1:0] add_result,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_W-1:0]  five_bit_muxout
);

  logic [1:0]        wb_q,   wb_d;
  logic [2:0]        m_q,    m_d;
  logic [DATA_W-1:0] add_q,  add_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] alu_q,  alu_d;
  logic [DATA_W-1:0] rd2_q,  rd2_d;
  logic [REG_W-1:0]  dst_q,  dst_d;

  // Next state: flush inserts an all-zero bubble, stall recirculates, otherwise load.
  always_comb begin
    wb_d   = wb_q;
    m_d    = m_q;
    add_d  = add_q;
    zero_d = zero_q;
    alu_d  = alu_q;
    rd2_d  = rd2_q;
    dst_d  = dst_q;
    if (flush) begin
      wb_d   = '0;
      m_d    = '0;
      add_d  = '0;
      zero_d = 1'b0;
      alu_d  = '0;
      rd2_d  = '0;
      dst_d  = '0;
    end else if (!stall) begin
      wb_d   = ctlwb_out;
      m_d    = ctlm_out;
      add_d  = adder_out;
      zero_d = aluzero;
      alu_d  = alu_out;
      rd2_d  = readdat2;
      dst_d  = mux_out;
    end
  end

  // State register; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q   <= '0;
      m_q    <= '0;
      add_q  <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      rd2_q  <= '0;
      dst_q  <= '0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      add_q  <= add_d;
      zero_q <= zero_d;
      alu_q  <= alu_d;
      rd2_q  <= rd2_d;
      dst_q  <= dst_d;
    end
  end

  assign wb_ctlout       = wb_q;
  assign m_ctlout        = m_q;
  assign add_result      = add_q;
  assign zero            = zero_q;
  assign alu_result      = alu_q;
  assign rdata2out       = rd2_q;
  assign five_bit_muxout = dst_q;

endmodule

// File: tb/tb_the_ex_stage.sv
// Bench for the EX/MEM pipeline register: directed cases then randomized traffic.
// Expected register contents come from a one-line-per-cycle behavioural model.
// Checks: every negedge (register must still hold model value) and every posedge via scoreboard.
module tb_the_ex_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        z;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  vec_t        in_v = '0;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  vec_t        dut_v;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  vec_t model = '0;

  always #5 clk = ~clk;

  the_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ctlwb_out(in_v.wb), .ctlm_out(in_v.m), .adder_out(in_v.add),
    .aluzero(in_v.z), .alu_out(in_v.alu), .readdat2(in_v.rd2), .mux_out(in_v.dst),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout)
  );

  assign dut_v = {wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out, five_bit_muxout};

  function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                              input logic z, input logic [31:0] alu, input logic [31:0] rd2,
                              input logic [4:0] dst);
    vec_t v;
    v = {wb, m, add, z, alu, rd2, dst};
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    return mk(2'($urandom), 3'($urandom), $urandom, 1'($urandom), $urandom, $urandom, 5'($urandom));
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at negedge, confirm the register has not moved,
  // then advance the model and queue what the next rising edge must produce.
  task automatic cycle(input vec_t in, input logic st, input logic fl, input logic rn);
    @(negedge clk);
    rst_n = rn;
    in_v  = in;
    stall = st;
    flush = fl;
    if (!rn) model = '0;
    #1;
    check("hold_between_edges", dut_v, model);
    if (rn) begin
      if (fl)       model = '0;
      else if (!st) model = in;
    end
    exp_q.push_back(model);
  endtask

  // Monitor: each rising edge presents a new register value; compare against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("after_edge", dut_v, exp_q.pop_front());
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a, b, hot;
    a   = mk(2'd1, 3'd2, 32'd3, 1'b0, 32'd5, 32'd6, 5'd7);
    b   = mk(2'd3, 3'd7, 32'hFFFF_FFFF, 1'b1, 32'hA5A5_A5A5, 32'h1234_5678, 5'd31);
    hot = mk(2'd3, 3'd5, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd21);

    // Reset held with busy inputs across several edges, including stall/flush.
    cycle(b, 1'b0, 1'b0, 1'b0);
    cycle(b, 1'b1, 1'b0, 1'b0);
    cycle(b, 1'b0, 1'b1, 1'b0);
    cycle(b, 1'b0, 1'b0, 1'b0);

    // First edge after release captures; then hold under stall; then load new values.
    cycle(a, 1'b0, 1'b0, 1'b1);
    cycle(b, 1'b1, 1'b0, 1'b1);
    cycle(b, 1'b1, 1'b0, 1'b1);
    cycle(b, 1'b0, 1'b0, 1'b1);

    // Flush wins over stall.
    cycle(a, 1'b1, 1'b1, 1'b1);
    cycle(a, 1'b0, 1'b0, 1'b1);

    // Async reset between edges while holding A5 pattern, then recapture.
    cycle(hot, 1'b0, 1'b0, 1'b1);
    cycle(hot, 1'b1, 1'b0, 1'b0);
    cycle(b,   1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(rnd_vec(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 29) != 0));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/the_ex_stage.md
THE_EX_STAGE -- requirements
Module: the_ex_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of adder_out, alu_out, readdat2 and their registered outputs.
REQ-002 The block SHALL have parameter REG_W, default 5, giving the width of mux_out and five_bit_muxout.

Ports:
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hold; when high, all registered outputs keep their current values.
REQ-007 flush  input  1  insert bubble; when high, all registered outputs load zero.
REQ-008 ctlwb_out  input  2  write-back control from EX.
REQ-009 ctlm_out  input  3  memory control from EX.
REQ-010 adder_out  input  DATA_W  branch-target adder result.
REQ-011 aluzero  input  1  ALU zero flag.
REQ-012 alu_out  input  DATA_W  ALU result.
REQ-013 readdat2  input  DATA_W  register-file read data 2 (store data).
REQ-014 mux_out  input  REG_W  destination-register select.
REQ-015 wb_ctlout  output  2  registered ctlwb_out.
REQ-016 m_ctlout  output  3  registered ctlm_out.
REQ-017 add_result  output  DATA_W  registered adder_out.
REQ-018 zero  output  1  registered aluzero.
REQ-019 alu_result  output  DATA_W  registered alu_out.
REQ-020 rdata2out  output  DATA_W  registered readdat2.
REQ-021 five_bit_muxout  output  REG_W  registered mux_out.

Function
REQ-022 The block SHALL be the EX/MEM pipeline register: every output is a flip-flop driven only by its same-named input, with no combinational input-to-output path.
REQ-023 On each rising clk edge with rst_n high, flush low and stall low, every output SHALL load its input, giving exactly one cycle of latency.
REQ-024 When stall is high and flush is low at a rising edge, every output SHALL keep its current value.
REQ-025 When flush is high at a rising edge, every output SHALL load zero, regardless of stall.
REQ-026 The priority order SHALL be: rst_n low, then flush, then stall, then normal load.
REQ-027 Values SHALL be transferred bit-exact, with no arithmetic, sign extension or truncation.
REQ-028 Input changes between clock edges SHALL NOT affect any output until the next rising edge.
REQ-029 With wb_ctlout = 0 and m_ctlout = 0 the register holds a bubble; downstream stages treat it as a no-op.

Reset
REQ-030 When rst_n goes low, all outputs SHALL go to zero immediately, without waiting for a clock edge.
REQ-031 While rst_n is low, all outputs SHALL stay at zero regardless of clk, stall or flush.
REQ-032 A reset asserted mid-operation SHALL discard the captured contents.
REQ-033 After rst_n is released, the first rising edge SHALL capture the inputs normally.

Verification
REQ-034 Reset: rst_n = 0 with all inputs nonzero -> all outputs 0 immediately and across multiple clk edges.
REQ-035 Capture: inputs ctlwb_out=1, ctlm_out=2, adder_out=3, aluzero=0, alu_out=5, readdat2=6, mux_out=7 with stall=0, flush=0 -> after one rising edge wb_ctlout=1, m_ctlout=2, add_result=3, zero=0, alu_result=5, rdata2out=6, five_bit_muxout=7; outputs unchanged before that edge.
REQ-036 Stall: after the REQ-035 capture, set stall=1 and change inputs to 3, 7, 0xFFFFFFFF, 1, 0xA5A5A5A5, 0x12345678, 31 -> outputs hold the REQ-035 values; after stall=0 and one edge, outputs equal the new values.
REQ-037 Flush: flush=1 and stall=1 with nonzero inputs -> all outputs 0 after the edge.
REQ-038 Async reset mid-stream: drop rst_n between edges while outputs hold 0xA5A5A5A5 -> outputs 0 without a clock edge; after release, the next edge captures the current inputs.
